// File: rtl/mdu.sv
// E-stage multiply/divide unit: HI/LO pair, multi-cycle mult/msub/div with a
// busy window for the hazard unit, single-cycle mt/mf/shl.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
  localparam logic [3:0] OpShl   = 4'd11;

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [1:0] {K_MUL, K_MSUB, K_DIV, K_DIV0} kind_e;

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*DataW-1:0]    pending_q, pending_d;
  logic [DataW-1:0]      hi_q, hi_d, lo_q, lo_d;

  logic                  is_mc_op;
  logic [2*DataW-1:0]    prod_s, prod_u;
  logic                  div_signed, a_neg, b_neg;
  logic [DataW-1:0]      a_mag, b_mag, uq, ur, quo, rem;

  // Full-width products; the low 64 bits of a sign-extended product are the signed result
  assign prod_s = {{DataW{A[DataW-1]}}, A} * {{DataW{B[DataW-1]}}, B};
  assign prod_u = {DataW'(0), A} * {DataW'(0), B};

  // One unsigned divider shared by div/divu; signed ops divide magnitudes and fix signs
  assign div_signed = (md_sel == OpDiv);
  assign a_neg      = div_signed & A[DataW-1];
  assign b_neg      = div_signed & B[DataW-1];
  assign a_mag      = a_neg ? (~A + DataW'(1)) : A;
  assign b_mag      = (B == '0) ? DataW'(1) : (b_neg ? (~B + DataW'(1)) : B);
  assign uq         = a_mag / b_mag;
  assign ur         = a_mag % b_mag;
  assign quo        = (a_neg ^ b_neg) ? (~uq + DataW'(1)) : uq;
  assign rem        = a_neg ? (~ur + DataW'(1)) : ur;

  always_comb begin
    is_mc_op = 1'b0;
    case (md_sel)
      OpMult, OpMultu, OpDiv, OpDivu, OpMsub, OpMsubu: is_mc_op = 1'b1;
      default:                                         is_mc_op = 1'b0;
    endcase
  end

  assign start = is_mc_op & (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    md_out = '0;
    case (md_sel)
      OpMfhi:  md_out = hi_q;
      OpMflo:  md_out = lo_q;
      default: md_out = '0;
    endcase
  end

  // Next-state: op launch and single-cycle moves in IDLE, countdown and writeback in RUN
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (is_mc_op) begin
          state_d = RUN;
          cnt_d   = CntW'(MULT_CYCLES);
          case (md_sel)
            OpMult: begin
              kind_d    = K_MUL;
              pending_d = prod_s;
            end
            OpMultu: begin
              kind_d    = K_MUL;
              pending_d = prod_u;
            end
            OpMsub: begin
              kind_d    = K_MSUB;
              pending_d = prod_s;
            end
            OpMsubu: begin
              kind_d    = K_MSUB;
              pending_d = prod_u;
            end
            default: begin
              cnt_d = CntW'(DIV_CYCLES);
              if (B == '0) begin
                kind_d    = K_DIV0;
                pending_d = '0;
              end else begin
                kind_d    = K_DIV;
                pending_d = {rem, quo};
              end
            end
          endcase
        end else begin
          case (md_sel)
            OpMthi:  hi_d = A;
            OpMtlo:  lo_d = A;
            OpShl:   {hi_d, lo_d} = {hi_q, lo_q} << B[4:0];
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          case (kind_q)
            K_MUL, K_DIV: {hi_d, lo_d} = pending_q;
            K_MSUB:       {hi_d, lo_d} = {hi_q, lo_q} - pending_q;
            default:      ;
          endcase
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      kind_q    <= K_MUL;
      cnt_q     <= '0;
      pending_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit of the E stage. It consumes the 4-bit `md_sel` code that the controller decodes for the E-stage instruction, together with the forwarded rs/rt operands. It holds the HI/LO register pair, runs multi-cycle multiply, multiply-subtract and divide operations, and performs single-cycle mt/mf/shl operations. It exposes `start`/`busy` so the hazard unit can stall D-stage md/mf/mt instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/msub/msubu (legal range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (legal range 1..15).

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state immediately.
- `md_sel`  input  4  operation code. Encoding:
  - 0 none
  - 1 mult, 2 multu, 3 div, 4 divu
  - 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
  - 9 msub, 10 msubu, 11 shl
  - 12..15 treated as none
- `A`  input  32  rs operand (forwarded).
- `B`  input  32  rt operand (forwarded).
- `start`  output  1  combinational. High in the cycle a multi-cycle op (1,2,3,4,9,10) is presented and `busy`=0.
- `busy`  output  1  registered. High while a multi-cycle op is in flight.
- `md_out`  output  32  combinational. HI for mfhi, LO for mflo, 0 otherwise.
- `hi`, `lo`  output  32 each  current HI/LO register values, for debug and the bench.

## Operation
- State is `IDLE` or `RUN`, plus a 4-bit down-counter `cnt`, a 64-bit `pending` result, a 2-bit `kind` (mul / msub / div / div0) and `HI`/`LO`.
- In `IDLE`, on a start-type `md_sel` at the clock edge:
  - latch op kind and compute `pending`;
  - load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to `RUN`.
- `pending` contents by op:
  - mult: signed A×B, 64 bits, HI=[63:32], LO=[31:0].
  - multu: unsigned A×B, same split.
  - msub/msubu: product latched now (signed/unsigned); subtraction happens at completion.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Signed-division special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, div or divu): still busy for `DIV_CYCLES`; HI/LO left unchanged at completion.
- In `RUN`, `cnt` decrements every edge. On the edge where `cnt` goes 1→0 the state returns to `IDLE` and the result is written:
  - mul kinds: {HI,LO} <= pending.
  - msub kinds: {HI,LO} <= {HI,LO} − product, modulo 2^64.
  - div0: no write.
- `busy` = (state == `RUN`).
- mthi/mtlo: HI<=A or LO<=A at the edge; only when `busy`=0.
- shl: {HI,LO} <= {HI,LO} << B[4:0], 64-bit logical shift, zeros in; single edge; only when `busy`=0.
- mfhi/mflo: no state change; `md_out` reflects the current register.
- Any op other than none presented while `busy`=1 is ignored (no state change, `start`=0). The hazard unit guarantees this never happens.

## Timing
- Reset values: state `IDLE`, `cnt`=0, `busy`=0, HI=LO=0, `pending`=0, `start`=0 (no op present), `md_out`=0.
- Cycle numbering for a multi-cycle op:
  - Cycle 0: op presented, `start`=1.
  - Cycles 1..N: `busy`=1.
  - Cycle N+1: `busy`=0 and the new HI/LO are visible on `hi`/`lo`/`md_out`.
- A second start-type op may be presented in cycle N+1. It starts with no gap and sees the updated HI/LO (msub chaining).
- mthi/mtlo/shl: new value visible the cycle after the op is presented. mf in the same cycle as mt returns the old value.
- Reset asserted mid-`RUN`: aborts immediately, discards `pending`, HI/LO=0, `busy`=0 asynchronously. After reset deassertion the unit is in `IDLE` on the next edge.
- `start` is combinational from `md_sel` and `busy`. `md_out` is combinational from `md_sel` and HI/LO. There are no other combinational input-to-output paths.

## Test plan
- Reset, then mult A=0xFFFFFFFE (−2), B=3:
  - `start`=1 in cycle 0, `busy`=1 for cycles 1..5;
  - cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA;
  - mfhi in cycle 6 gives `md_out`=0xFFFFFFFF.
- multu A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles. Then msubu A=1, B=1 issued in cycle 6 → HI=0xFFFFFFFE, LO=0x00000000.
- Signed division:
  - div A=−7 (0xFFFFFFF9), B=2 → 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: mthi 0x12345678, mtlo 0x9ABCDEF0, then divu B=0 → busy 10 cycles; HI/LO unchanged afterwards.
- Move and shift, with HI=0, LO=0x80000001:
  - shl B=1 → HI=0x00000001, LO=0x00000002 next cycle;
  - mtlo issued while `busy`=1 → LO unchanged, `start`=0.
- Reset mid-divide: pull `reset` low in busy cycle 4 → `busy`=0 and HI=LO=0 immediately. A mult issued after release completes normally.
